// File: rtl/stopwatch_lap_timer_if.sv
// Control and display bundle of the BCD stopwatch with lap hold.
// master drives the controls and reads the display; slave is the timer itself.
interface stopwatch_lap_timer_if;
    logic        Enable;
    logic        Clear;
    logic        Dir;
    logic        Load;
    logic [23:0] Preset;
    logic        Lap;
    logic [3:0]  sec0;
    logic [3:0]  sec1;
    logic [3:0]  min0;
    logic [3:0]  min1;
    logic [3:0]  hr0;
    logic [3:0]  hr1;
    logic        lap_active;
    logic        done;
    logic        wrap;
    logic        load_err;

    modport master (
        output Enable, Clear, Dir, Load, Preset, Lap,
        input  sec0, sec1, min0, min1, hr0, hr1, lap_active, done, wrap, load_err
    );

    modport slave (
        input  Enable, Clear, Dir, Load, Preset, Lap,
        output sec0, sec1, min0, min1, hr0, hr1, lap_active, done, wrap, load_err
    );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// Up/down BCD HH:MM:SS timer with tick prescaler, hour modulus, preset load,
// lap hold and sticky countdown-done flag.
module stopwatch_lap_timer #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned HR_LIMIT      = 24
) (
    input  logic                  CLK,
    input  logic                  RESET,
    stopwatch_lap_timer_if.slave  bus
);

    typedef struct packed {
        logic [3:0] hr1;
        logic [3:0] hr0;
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
    } bcd_time_t;

    localparam int unsigned     PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   TERM    = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]      HR_MAX1 = 4'((HR_LIMIT - 1) / 10);
    localparam logic [3:0]      HR_MAX0 = 4'((HR_LIMIT - 1) % 10);
    localparam bcd_time_t       T_MAX   = '{hr1: HR_MAX1, hr0: HR_MAX0,
                                            min1: 4'd5, min0: 4'd9,
                                            sec1: 4'd5, sec0: 4'd9};

    bcd_time_t        live_q, live_d;
    bcd_time_t        hold_q, hold_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             lap_active_q, lap_active_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    bcd_time_t        preset;
    bcd_time_t        display;
    logic             tick;
    logic             preset_ok;
    logic [6:0]       preset_hr;

    function automatic bcd_time_t inc_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec0 != 4'd9) r.sec0 = t.sec0 + 4'd1;
        else begin
            r.sec0 = 4'd0;
            if (t.sec1 != 4'd5) r.sec1 = t.sec1 + 4'd1;
            else begin
                r.sec1 = 4'd0;
                if (t.min0 != 4'd9) r.min0 = t.min0 + 4'd1;
                else begin
                    r.min0 = 4'd0;
                    if (t.min1 != 4'd5) r.min1 = t.min1 + 4'd1;
                    else begin
                        r.min1 = 4'd0;
                        if (t.hr1 == HR_MAX1 && t.hr0 == HR_MAX0) begin
                            r.hr1 = 4'd0;
                            r.hr0 = 4'd0;
                        end else if (t.hr0 != 4'd9) begin
                            r.hr0 = t.hr0 + 4'd1;
                        end else begin
                            r.hr0 = 4'd0;
                            r.hr1 = t.hr1 + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Saturates at 00:00:00; the hour borrow is only reached with a nonzero total.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t == '0) return r;
        if (t.sec0 != 4'd0) r.sec0 = t.sec0 - 4'd1;
        else begin
            r.sec0 = 4'd9;
            if (t.sec1 != 4'd0) r.sec1 = t.sec1 - 4'd1;
            else begin
                r.sec1 = 4'd5;
                if (t.min0 != 4'd0) r.min0 = t.min0 - 4'd1;
                else begin
                    r.min0 = 4'd9;
                    if (t.min1 != 4'd0) r.min1 = t.min1 - 4'd1;
                    else begin
                        r.min1 = 4'd5;
                        if (t.hr0 != 4'd0) r.hr0 = t.hr0 - 4'd1;
                        else begin
                            r.hr0 = 4'd9;
                            r.hr1 = t.hr1 - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign preset    = bcd_time_t'(bus.Preset);
    assign preset_hr = 7'(preset.hr1) * 7'd10 + 7'(preset.hr0);
    assign preset_ok = (preset.sec0 <= 4'd9) && (preset.sec1 <= 4'd5) &&
                       (preset.min0 <= 4'd9) && (preset.min1 <= 4'd5) &&
                       (preset.hr0  <= 4'd9) && (preset.hr1  <= 4'd9) &&
                       (preset_hr < 7'(HR_LIMIT));
    assign tick      = bus.Enable && (presc_q == TERM);

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        live_d       = live_q;
        hold_d       = hold_q;
        presc_d      = presc_q;
        lap_active_d = lap_active_q;
        done_d       = done_q;
        wrap_d       = 1'b0;
        load_err_d   = 1'b0;

        // Lap snapshots the count as it stood before this edge's tick.
        if (bus.Lap && !bus.Clear) begin
            if (!lap_active_q) begin
                hold_d       = live_q;
                lap_active_d = 1'b1;
            end else begin
                lap_active_d = 1'b0;
            end
        end

        if (bus.Clear) begin
            live_d       = '0;
            presc_d      = '0;
            done_d       = 1'b0;
            lap_active_d = 1'b0;
        end else if (bus.Load) begin
            if (preset_ok) begin
                live_d  = preset;
                presc_d = '0;
                done_d  = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.Enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (!bus.Dir) begin
                    live_d = inc_time(live_q);
                    wrap_d = (live_q == T_MAX);
                end else begin
                    live_d = dec_time(live_q);
                    if (live_d == '0) done_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            live_q       <= '0;
            hold_q       <= '0;
            presc_q      <= '0;
            lap_active_q <= 1'b0;
            done_q       <= 1'b0;
            wrap_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            live_q       <= live_d;
            hold_q       <= hold_d;
            presc_q      <= presc_d;
            lap_active_q <= lap_active_d;
            done_q       <= done_d;
            wrap_q       <= wrap_d;
            load_err_q   <= load_err_d;
        end
    end

    assign display        = lap_active_q ? hold_q : live_q;
    assign bus.sec0       = display.sec0;
    assign bus.sec1       = display.sec1;
    assign bus.min0       = display.min0;
    assign bus.min1       = display.min1;
    assign bus.hr0        = display.hr0;
    assign bus.hr1        = display.hr1;
    assign bus.lap_active = lap_active_q;
    assign bus.done       = done_q;
    assign bus.wrap       = wrap_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: two instances (1 tick/s, 24 h and 4 ticks/s, 12 h)
// checked every cycle against a seconds-count model, plus directed literal checks.
module tb_stopwatch_lap_timer;

    logic clk;
    logic rst;

    stopwatch_lap_timer_if ifa ();
    stopwatch_lap_timer_if ifb ();

    stopwatch_lap_timer #(.TICKS_PER_SEC(1), .HR_LIMIT(24)) dut_a (.CLK(clk), .RESET(rst), .bus(ifa));
    stopwatch_lap_timer #(.TICKS_PER_SEC(4), .HR_LIMIT(12)) dut_b (.CLK(clk), .RESET(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    int tps [2] = '{1, 4};
    int hrl [2] = '{24, 12};

    // Model state: total seconds, prescaler phase, held seconds and flags.
    int secs [2];
    int pre  [2];
    int hold [2];
    bit lap  [2];
    bit done [2];
    bit wrap [2];
    bit lerr [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit preset_valid(input int i, input logic [23:0] p);
        int d [6];
        for (int k = 0; k < 6; k++) d[k] = int'(p[k*4 +: 4]);
        for (int k = 0; k < 6; k++) if (d[k] > 9) return 1'b0;
        if (d[1] > 5 || d[3] > 5) return 1'b0;
        return (d[5] * 10 + d[4]) < hrl[i];
    endfunction

    function automatic int preset_secs(input logic [23:0] p);
        return (int'(p[23:20]) * 10 + int'(p[19:16])) * 3600 +
               (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 +
               int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            secs[i] = 0; pre[i] = 0; hold[i] = 0;
            lap[i] = 0; done[i] = 0; wrap[i] = 0; lerr[i] = 0;
        end
    endtask

    task automatic model_update(input int i, input logic en, input logic clr, input logic dir,
                                input logic ld, input logic [23:0] p, input logic lp);
        wrap[i] = 1'b0;
        lerr[i] = 1'b0;
        if (lp && !clr) begin
            if (!lap[i]) begin
                hold[i] = secs[i];
                lap[i]  = 1'b1;
            end else begin
                lap[i] = 1'b0;
            end
        end
        if (clr) begin
            secs[i] = 0; pre[i] = 0; done[i] = 1'b0; lap[i] = 1'b0;
        end else if (ld) begin
            if (preset_valid(i, p)) begin
                secs[i] = preset_secs(p); pre[i] = 0; done[i] = 1'b0;
            end else begin
                lerr[i] = 1'b1;
            end
        end else if (en) begin
            if (pre[i] == tps[i] - 1) begin
                pre[i] = 0;
                if (!dir) begin
                    if (secs[i] == hrl[i] * 3600 - 1) begin
                        secs[i] = 0; wrap[i] = 1'b1;
                    end else begin
                        secs[i]++;
                    end
                end else begin
                    if (secs[i] > 0) secs[i]--;
                    if (secs[i] == 0) done[i] = 1'b1;
                end
            end else begin
                pre[i]++;
            end
        end
    endtask

    function automatic logic [23:0] dig_a();
        return {ifa.hr1, ifa.hr0, ifa.min1, ifa.min0, ifa.sec1, ifa.sec0};
    endfunction

    function automatic logic [23:0] dig_b();
        return {ifb.hr1, ifb.hr0, ifb.min1, ifb.min0, ifb.sec1, ifb.sec0};
    endfunction

    function automatic logic [23:0] exp_disp(input int i);
        return to_bcd(lap[i] ? hold[i] : secs[i]);
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            check("a_display",  32'(dig_a()),      32'(exp_disp(0)));
            check("a_lap",      32'(ifa.lap_active), 32'(lap[0]));
            check("a_done",     32'(ifa.done),     32'(done[0]));
            check("a_wrap",     32'(ifa.wrap),     32'(wrap[0]));
            check("a_load_err", 32'(ifa.load_err), 32'(lerr[0]));
            check("b_display",  32'(dig_b()),      32'(exp_disp(1)));
            check("b_lap",      32'(ifb.lap_active), 32'(lap[1]));
            check("b_done",     32'(ifb.done),     32'(done[1]));
            check("b_wrap",     32'(ifb.wrap),     32'(wrap[1]));
            check("b_load_err", 32'(ifb.load_err), 32'(lerr[1]));
        end
    end

    task automatic drive(input logic en, input logic clr, input logic dir, input logic ld,
                         input logic [23:0] p, input logic lp, input logic ld_b);
        ifa.Enable = en; ifa.Clear = clr; ifa.Dir = dir; ifa.Load = ld; ifa.Preset = p; ifa.Lap = lp;
        ifb.Enable = en; ifb.Clear = clr; ifb.Dir = dir; ifb.Load = ld_b; ifb.Preset = p; ifb.Lap = lp;
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (!rst) begin
            model_update(0, ifa.Enable, ifa.Clear, ifa.Dir, ifa.Load, ifa.Preset, ifa.Lap);
            model_update(1, ifb.Enable, ifb.Clear, ifb.Dir, ifb.Load, ifb.Preset, ifb.Lap);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            edge_update();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] p;
        logic        ld, dir;
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        #1;
        cmp_on = 1'b1;
        step(2);
        check("reset_display", 32'(dig_a()), 32'h0);
        do_reset();

        // 1: plain 1 Hz count for 12 edges.
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        step(12);
        check("t1_time", 32'(dig_a()), 32'h000012);
        check("t1_wrap", 32'(ifa.wrap), 32'h0);
        check("t1_done", 32'(ifa.done), 32'h0);

        // 2: prescaler of 4 holds its phase through a pause.
        do_reset();
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        step(6);
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        step(10);
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        step(1);
        check("t2_edge7", 32'(dig_b()), 32'h000001);
        step(1);
        check("t2_edge8", 32'(dig_b()), 32'h000002);

        // 3: rollover with wrap, then a rejected load.
        drive(0, 0, 0, 1, 24'h235958, 0, 0);
        step(1);
        check("t3_loaded", 32'(dig_a()), 32'h235958);
        check("t3_b_reject", 32'(ifb.load_err), 32'h0);
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        step(1);
        check("t3_tick1", 32'(dig_a()), 32'h235959);
        check("t3_wrap0", 32'(ifa.wrap), 32'h0);
        step(1);
        check("t3_tick2", 32'(dig_a()), 32'h000000);
        check("t3_wrap1", 32'(ifa.wrap), 32'h1);
        drive(0, 0, 0, 1, 24'h006000, 0, 0);
        step(1);
        check("t3_load_err", 32'(ifa.load_err), 32'h1);
        check("t3_unchanged", 32'(dig_a()), 32'h000000);
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        step(1);
        check("t3_err_pulse", 32'(ifa.load_err), 32'h0);

        // 4: countdown to zero, saturation, clear of done.
        drive(0, 0, 1, 1, 24'h000101, 0, 1);
        step(1);
        drive(1, 0, 1, 0, 24'h0, 0, 0);
        step(60);
        check("t4_tick60", 32'(dig_a()), 32'h000001);
        check("t4_not_done", 32'(ifa.done), 32'h0);
        step(1);
        check("t4_zero", 32'(dig_a()), 32'h000000);
        check("t4_done", 32'(ifa.done), 32'h1);
        step(5);
        check("t4_hold_zero", 32'(dig_a()), 32'h000000);
        check("t4_done_sticky", 32'(ifa.done), 32'h1);
        drive(0, 1, 1, 0, 24'h0, 0, 0);
        step(1);
        check("t4_clear_done", 32'(ifa.done), 32'h0);

        // 5: lap hold while the live count keeps running.
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        step(5);
        check("t5_run", 32'(dig_a()), 32'h000005);
        drive(1, 0, 0, 0, 24'h0, 1, 0);
        step(1);
        check("t5_held", 32'(dig_a()), 32'h000005);
        check("t5_lap_on", 32'(ifa.lap_active), 32'h1);
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        step(3);
        check("t5_still_held", 32'(dig_a()), 32'h000005);
        drive(1, 0, 0, 0, 24'h0, 1, 0);
        step(1);
        check("t5_live", 32'(dig_a()), 32'h000010);
        check("t5_lap_off", 32'(ifa.lap_active), 32'h0);

        // 6: asynchronous reset mid-count with a lap held.
        drive(0, 0, 0, 1, 24'h000316, 0, 1);
        step(1);
        drive(1, 0, 0, 0, 24'h0, 1, 0);
        edge_update();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_digits", 32'(dig_a()), 32'h0);
        check("t6_lap", 32'(ifa.lap_active), 32'h0);
        check("t6_done", 32'(ifa.done), 32'h0);
        check("t6_b_digits", 32'(dig_b()), 32'h0);
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(3);
        check("t6_restart", 32'(dig_a()), 32'h000003);

        // Random phase: the per-cycle compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 50) begin
                p = to_bcd(int'($urandom_range(23)) * 3600 + int'($urandom_range(59)) * 60 +
                           int'($urandom_range(59)));
                if ($urandom_range(9) < 3) p = to_bcd(int'($urandom_range(9)));
            end else begin
                p = 24'($urandom);
            end
            ld = ($urandom_range(99) < 5);
            if ($urandom_range(99) < 5) dir = ~ifa.Dir;
            else dir = ifa.Dir;
            drive($urandom_range(99) < 85, $urandom_range(99) < 2, dir, ld, p,
                  $urandom_range(99) < 5, ld && preset_valid(1, p));
            step(1);
        end

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
